// File: rtl/read_burst_engine.sv
`default_nettype none
// ============================================================================
// Module   : read_burst_engine
// Brief    : Avalon-MM read master that fetches word_count words one at a time,
//            streams them out with valid/ready and keeps a running checksum.
// Revision : 1.0 - initial release
// ============================================================================
module read_burst_engine (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] word_count,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic [31:0] data_out,
  output logic        data_valid,
  input  logic        data_ready,
  output logic [31:0] checksum,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);

  localparam logic [1:0] c_IDLE      = 2'd0;
  localparam logic [1:0] c_ISSUE     = 2'd1;
  localparam logic [1:0] c_WAIT_DATA = 2'd2;
  localparam logic [1:0] c_PUSH      = 2'd3;

  // Counter value in the 255th WAIT_DATA cycle (counter starts at 0 on entry).
  localparam logic [7:0] c_WAIT_LAST = 8'd254;

  logic [1:0]  r_state;
  logic [31:0] r_addr;
  logic [15:0] r_remaining;
  logic [7:0]  r_wait_cnt;
  logic [31:0] r_data_out;
  logic [31:0] r_checksum;
  logic        r_done;
  logic        r_timeout_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= c_IDLE;
      r_addr        <= 32'd0;
      r_remaining   <= 16'd0;
      r_wait_cnt    <= 8'd0;
      r_data_out    <= 32'd0;
      r_checksum    <= 32'd0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_checksum    <= 32'd0;
            r_timeout_err <= 1'b0;
            if (word_count == 16'd0) begin
              r_done <= 1'b1;
            end else begin
              r_done      <= 1'b0;
              r_addr      <= base_addr;
              r_remaining <= word_count;
              r_state     <= c_ISSUE;
            end
          end
        end
        c_ISSUE: begin
          if (!avm_waitrequest) begin
            r_wait_cnt <= 8'd0;
            r_state    <= c_WAIT_DATA;
          end
        end
        c_WAIT_DATA: begin
          // Data arriving in the final wait cycle wins over the timeout.
          if (avm_readdatavalid) begin
            r_data_out <= avm_readdata;
            r_checksum <= r_checksum + avm_readdata;
            r_state    <= c_PUSH;
          end else if (r_wait_cnt == c_WAIT_LAST) begin
            r_timeout_err <= 1'b1;
            r_done        <= 1'b1;
            r_state       <= c_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        c_PUSH: begin
          if (data_ready) begin
            r_remaining <= r_remaining - 16'd1;
            r_addr      <= r_addr + 32'd4;
            if (r_remaining == 16'd1) begin
              r_done  <= 1'b1;
              r_state <= c_IDLE;
            end else begin
              r_state <= c_ISSUE;
            end
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign avm_read    = (r_state == c_ISSUE);
  assign avm_address = avm_read ? r_addr : 32'd0;
  assign data_valid  = (r_state == c_PUSH);
  assign data_out    = r_data_out;
  assign checksum    = r_checksum;
  assign busy        = (r_state != c_IDLE);
  assign done        = r_done;
  assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_read_burst_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_read_burst_engine
// Brief    : Directed bench with an Avalon read slave model and stream monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_read_burst_engine;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = 32'd0;
  logic [15:0] word_count = 16'd0;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic [31:0] data_out;
  logic        data_valid;
  logic        data_ready = 1'b1;
  logic [31:0] checksum;
  logic        busy;
  logic        done;
  logic        timeout_err;

  read_burst_engine dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .base_addr         (base_addr),
    .word_count        (word_count),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .data_out          (data_out),
    .data_valid        (data_valid),
    .data_ready        (data_ready),
    .checksum          (checksum),
    .busy              (busy),
    .done              (done),
    .timeout_err       (timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Slave model state and observation logs
  int          stall_cfg = 0, stall_left = 0, lat_cfg = 1, pend_cnt = 0;
  bit          silent = 1'b0;
  logic [31:0] rsp_word = 32'd0;
  logic [31:0] rsp_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] out_q[$];
  int          n_reads = 0, n_rd_cyc = 0, n_dv_cyc = 0, n_addr_chg = 0, n_do_chg = 0, n_wait = 0;
  logic        prev_rd = 1'b0, prev_dv = 1'b0, prev_hs = 1'b0;
  logic [31:0] prev_addr = 32'd0, prev_do = 32'd0;
  int          snap;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic setup(input int stall, input int lat, input bit quiet);
    stall_cfg = stall; stall_left = stall; lat_cfg = lat; silent = quiet; pend_cnt = 0;
    rsp_q.delete(); addr_q.delete(); out_q.delete();
    n_reads = 0; n_rd_cyc = 0; n_dv_cyc = 0; n_addr_chg = 0; n_do_chg = 0; n_wait = 0;
  endtask

  task automatic do_start(input logic [31:0] a, input logic [15:0] n);
    base_addr = a; word_count = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Avalon read slave: stalls stall_cfg cycles per read, answers lat_cfg cycles after accept
  initial begin
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = 32'd0;
    forever begin
      @(negedge clk);
      avm_readdatavalid = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0 && !silent) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = rsp_word;
        end
      end
      if (avm_read && stall_left > 0) begin
        avm_waitrequest = 1'b1;
        stall_left--;
      end else begin
        avm_waitrequest = 1'b0;
        if (avm_read) begin
          addr_q.push_back(avm_address);
          n_reads++;
          if (rsp_q.size() > 0) rsp_word = rsp_q.pop_front();
          else                  rsp_word = 32'd0;
          pend_cnt   = lat_cfg;
          stall_left = stall_cfg;
        end
      end
    end
  end

  // Monitor samples settled values just after each falling edge
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (avm_read) begin
        n_rd_cyc++;
        if (prev_rd && avm_address != prev_addr) n_addr_chg++;
      end
      if (data_valid) begin
        n_dv_cyc++;
        if (prev_dv && !prev_hs && data_out != prev_do) n_do_chg++;
        if (data_ready) out_q.push_back(data_out);
      end
      if (busy && !avm_read && !data_valid) n_wait++;
      prev_rd = avm_read; prev_addr = avm_address;
      prev_dv = data_valid; prev_do = data_out; prev_hs = data_valid & data_ready;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    setup(0, 1, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_read",   32'(avm_read), 32'd0);
    check("rst_addr",   avm_address, 32'd0);
    check("rst_dvalid", 32'(data_valid), 32'd0);
    check("rst_flags",  {30'd0, done, timeout_err}, 32'd0);
    check("rst_csum",   checksum, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Three-word burst, no stalls
    setup(0, 1, 1'b0);
    rsp_q = {32'd1, 32'd2, 32'd3};
    do_start(32'h0000_1000, 16'd3);
    wait_idle(200, "t1_idle");
    check("t1_nreads", 32'(n_reads), 32'd3);
    check("t1_addr0", addr_q[0], 32'h0000_1000);
    check("t1_addr1", addr_q[1], 32'h0000_1004);
    check("t1_addr2", addr_q[2], 32'h0000_1008);
    check("t1_nout",  32'(out_q.size()), 32'd3);
    check("t1_out0",  out_q[0], 32'd1);
    check("t1_out1",  out_q[1], 32'd2);
    check("t1_out2",  out_q[2], 32'd3);
    check("t1_csum",  checksum, 32'd6);
    check("t1_done",  32'(done), 32'd1);
    check("t1_busy",  32'(busy), 32'd0);
    check("t1_dvcyc", 32'(n_dv_cyc), 32'd3);

    // Waitrequest for 5 cycles, then downstream back-pressure for 4 cycles
    setup(5, 1, 1'b0);
    rsp_q = {32'hA5A5_0001};
    data_ready = 1'b0;
    do_start(32'h0000_2000, 16'd1);
    for (int k = 0; k < 50 && !data_valid; k++) @(negedge clk);
    check("t2_dv_seen", 32'(data_valid), 32'd1);
    repeat (3) @(negedge clk);
    @(negedge clk);
    data_ready = 1'b1;
    wait_idle(50, "t2_idle");
    check("t2_nreads",  32'(n_reads), 32'd1);
    check("t2_rdcyc",   32'(n_rd_cyc), 32'd6);
    check("t2_addrchg", 32'(n_addr_chg), 32'd0);
    check("t2_addr0",   addr_q[0], 32'h0000_2000);
    check("t2_dvcyc",   32'(n_dv_cyc), 32'd5);
    check("t2_dochg",   32'(n_do_chg), 32'd0);
    check("t2_out0",    out_q[0], 32'hA5A5_0001);

    // Slave never answers: timeout after 255 WAIT_DATA cycles
    setup(0, 1, 1'b1);
    do_start(32'h0000_3000, 16'd1);
    wait_idle(400, "t4_idle");
    check("t4_nwait",   32'(n_wait), 32'd255);
    check("t4_timeout", 32'(timeout_err), 32'd1);
    check("t4_done",    32'(done), 32'd1);
    check("t4_busy",    32'(busy), 32'd0);
    setup(0, 1, 1'b0);
    rsp_q = {32'h0000_0055};
    do_start(32'h0000_3000, 16'd1);
    check("t4_clr_done", 32'(done), 32'd0);
    check("t4_clr_to",   32'(timeout_err), 32'd0);
    wait_idle(50, "t4b_idle");
    check("t4b_done", 32'(done), 32'd1);
    check("t4b_out",  out_q[0], 32'h0000_0055);

    // Address wrap and checksum carry discard
    setup(0, 1, 1'b0);
    rsp_q = {32'hFFFF_FFFF, 32'h0000_0002};
    do_start(32'hFFFF_FFFC, 16'd2);
    wait_idle(100, "t5_idle");
    check("t5_addr0", addr_q[0], 32'hFFFF_FFFC);
    check("t5_addr1", addr_q[1], 32'h0000_0000);
    check("t5_csum",  checksum, 32'h0000_0001);

    // Zero-length start clears a nonzero checksum without any bus read
    setup(0, 1, 1'b0);
    do_start(32'h0000_7000, 16'd0);
    check("t3_done", 32'(done), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_csum", checksum, 32'd0);
    repeat (5) @(negedge clk);
    check("t3_rdcyc", 32'(n_rd_cyc), 32'd0);

    // Start while busy is ignored
    setup(0, 3, 1'b0);
    rsp_q = {32'd10, 32'd20};
    do_start(32'h0000_4000, 16'd2);
    repeat (2) @(negedge clk);
    do_start(32'h0000_5000, 16'd1);
    wait_idle(100, "t6_idle");
    check("t6_nreads", 32'(n_reads), 32'd2);
    check("t6_addr1",  addr_q[1], 32'h0000_4004);
    check("t6_csum",   checksum, 32'd30);

    // Reset in the middle of a transfer
    setup(0, 3, 1'b0);
    rsp_q = {32'd7, 32'd8, 32'd9, 32'd10};
    do_start(32'h0000_6000, 16'd4);
    repeat (6) @(negedge clk);
    reset_n = 1'b0;
    #1;
    snap = n_reads;
    check("t6r_busy",  32'(busy), 32'd0);
    check("t6r_read",  32'(avm_read), 32'd0);
    check("t6r_dv",    32'(data_valid), 32'd0);
    check("t6r_dout",  data_out, 32'd0);
    check("t6r_csum",  checksum, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("t6r_noread", 32'(n_reads), 32'(snap));
    check("t6r_done",   32'(done), 32'd0);
    check("t6r_busy2",  32'(busy), 32'd0);

    // Zero-length start after reset raises done one cycle later
    setup(0, 1, 1'b0);
    do_start(32'h0000_8000, 16'd0);
    check("t7_done", 32'(done), 32'd1);
    check("t7_to",   32'(timeout_err), 32'd0);
    repeat (3) @(negedge clk);
    check("t7_nreads", 32'(n_reads), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
